// File: rtl/shreg_pkg.sv
// ============================================================================
// Module      : shreg_pkg
// Description : Shared types for the universal shift register (shift mode and
//               FSM state encodings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shreg_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'd0,
        MODE_LSR = 2'd1,
        MODE_ASR = 2'd2,
        MODE_ROR = 2'd3
    } shift_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shreg_state_t;

endpackage

`default_nettype wire

// File: rtl/shreg_step.sv
// ============================================================================
// Module      : shreg_step
// Description : Combinational single-bit shift/rotate step with shifted-out bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_cur,
    input  shift_mode_t      i_mode,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_next,
    output logic             o_sout
);

    always_comb begin
        o_next = i_cur;
        o_sout = i_cur[0];
        case (i_mode)
            MODE_LSL: begin
                o_next = {i_cur[WIDTH-2:0], i_sin};
                o_sout = i_cur[WIDTH-1];
            end
            MODE_LSR: o_next = {i_sin, i_cur[WIDTH-1:1]};
            MODE_ASR: o_next = {i_cur[WIDTH-1], i_cur[WIDTH-1:1]};
            MODE_ROR: o_next = {i_cur[0], i_cur[WIDTH-1:1]};
            default:  o_next = i_cur;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register, parallel load plus serial multi-bit
//               shifts under start/busy/done. Optional UNIV_SHIFT_REG_ABORT_EN
//               adds an i_abort port that cancels a shift in progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_amount,
    input  logic             i_sin,
`ifdef UNIV_SHIFT_REG_ABORT_EN
    input  logic             i_abort,
`endif
    output logic [WIDTH-1:0] o_out,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    shreg_state_t     r_state, w_state_nxt;
    shift_mode_t      r_mode,  w_mode_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [WIDTH-1:0] r_out,   w_out_nxt;
    logic             r_sout,  w_sout_nxt;
    logic             r_done,  w_done_nxt;

    logic [WIDTH-1:0] w_step_out;
    logic             w_step_sout;
    logic             w_abort;

`ifdef UNIV_SHIFT_REG_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_cur  (r_out),
        .i_mode (r_mode),
        .i_sin  (i_sin),
        .o_next (w_step_out),
        .o_sout (w_step_sout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_LSL;
            r_cnt   <= '0;
            r_out   <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_sout  <= w_sout_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_sout_nxt  = r_sout;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_out_nxt = i_data;
                end else if (i_start) begin
                    w_mode_nxt = shift_mode_t'(i_mode);
                    w_cnt_nxt  = i_amount;
                    if (i_amount == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // Abort leaves the partial result in place and skips the done pulse.
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_out_nxt  = w_step_out;
                    w_sout_nxt = w_step_sout;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_out  = r_out;
    assign o_sout = r_sout;
    assign o_busy = (r_state == ST_SHIFT);
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Directed self-checking bench for univ_shift_reg at WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_load = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_start = 1'b0;
    logic [1:0]       i_mode = 2'd0;
    logic [CNT_W-1:0] i_amount = '0;
    logic             i_sin = 1'b0;
`ifdef UNIV_SHIFT_REG_ABORT_EN
    logic             i_abort = 1'b0;
`endif
    logic [WIDTH-1:0] o_out;
    logic             o_sout;
    logic             o_busy;
    logic             o_done;

    int n_vec = 0;
    int n_err = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (i_load),
        .i_data   (i_data),
        .i_start  (i_start),
        .i_mode   (i_mode),
        .i_amount (i_amount),
        .i_sin    (i_sin),
`ifdef UNIV_SHIFT_REG_ABORT_EN
        .i_abort  (i_abort),
`endif
        .o_out    (o_out),
        .o_sout   (o_sout),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] d);
        i_load = 1'b1;
        i_data = d;
        tick();
        i_load = 1'b0;
        chk("load_out", 32'(o_out), 32'(d));
    endtask

    // Start an op and wait for done; checks latency, busy length and result.
    task automatic run_op(input string tag, input logic [1:0] mode, input int amt,
                          input logic sin, input logic mid_load,
                          input logic [WIDTH-1:0] exp_out, input logic exp_sout);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        i_mode   = mode;
        i_amount = CNT_W'(amt);
        i_sin    = sin;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        if (mid_load) begin
            i_load = 1'b1;
            i_data = 16'hAAAA;
        end
        while (!o_done && lat < 100) begin
            busy_cnt += int'(o_busy);
            tick();
            lat++;
        end
        i_load = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(amt));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(amt));
        chk({tag, "_out"}, 32'(o_out), 32'(exp_out));
        chk({tag, "_sout"}, 32'(o_sout), 32'(exp_sout));
        chk({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        // Reset state
        i_rst = 1'b1;
        #12;
        chk("rst_out", 32'(o_out), 32'h0);
        chk("rst_sout", 32'(o_sout), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        i_rst = 1'b0;
        tick();

        // LSL by 1
        load(16'h8001);
        chk("load_no_done", 32'(o_done), 32'h0);
        run_op("lsl1", 2'd0, 1, 1'b0, 1'b0, 16'h0002, 1'b1);
        tick();
        chk("lsl1_done_one_cycle", 32'(o_done), 32'h0);

        // Back-to-back: start accepted in the cycle done is high
        run_op("lsl1_a", 2'd0, 1, 1'b0, 1'b0, 16'h0004, 1'b0);
        i_mode = 2'd0; i_amount = 5'd1; i_sin = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("b2b_busy", 32'(o_busy), 32'h1);
        tick();
        chk("b2b_done", 32'(o_done), 32'h1);
        chk("b2b_out", 32'(o_out), 32'h0009);

        // ASR saturation
        load(16'h8000);
        run_op("asr4", 2'd2, 4, 1'b0, 1'b0, 16'hF800, 1'b0);
        run_op("asr20", 2'd2, 20, 1'b0, 1'b0, 16'hFFFF, 1'b1);

        // ROR wrap
        load(16'h0001);
        run_op("ror4", 2'd3, 4, 1'b0, 1'b0, 16'h1000, 1'b0);
        run_op("ror16", 2'd3, 16, 1'b0, 1'b0, 16'h1000, 1'b0);

        // LSR with serial fill, load ignored mid-shift
        load(16'h0000);
        run_op("lsr3", 2'd1, 3, 1'b1, 1'b1, 16'hE000, 1'b0);

        // LSL longer than width keeps the last WIDTH fill bits
        run_op("lsl20", 2'd0, 20, 1'b1, 1'b0, 16'hFFFF, 1'b1);

        // Amount zero
        load(16'h1234);
        i_mode = 2'd1; i_amount = 5'd0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("amt0_done", 32'(o_done), 32'h1);
        chk("amt0_busy", 32'(o_busy), 32'h0);
        chk("amt0_out", 32'(o_out), 32'h1234);
        tick();
        chk("amt0_done_clear", 32'(o_done), 32'h0);

        // Load wins over start
        i_load = 1'b1; i_data = 16'h5A5A; i_start = 1'b1; i_amount = 5'd3;
        tick();
        i_load = 1'b0; i_start = 1'b0;
        chk("ldst_out", 32'(o_out), 32'h5A5A);
        chk("ldst_busy", 32'(o_busy), 32'h0);
        chk("ldst_done", 32'(o_done), 32'h0);

        // Async reset mid-shift
        load(16'h0001);
        i_mode = 2'd3; i_amount = 5'd10; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_busy", 32'(o_busy), 32'h1);
        chk("pre_rst_out", 32'(o_out), 32'h1000);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_out", 32'(o_out), 32'h0);
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        chk("mid_rst_sout", 32'(o_sout), 32'h0);
        i_rst = 1'b0;
        tick();
        tick();
        chk("post_rst_busy", 32'(o_busy), 32'h0);
        chk("post_rst_done", 32'(o_done), 32'h0);

`ifdef UNIV_SHIFT_REG_ABORT_EN
        load(16'h0001);
        i_mode = 2'd3; i_amount = 5'd10; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_out", 32'(o_out), 32'h1000);
        chk("abort_busy", 32'(o_busy), 32'h0);
        chk("abort_done", 32'(o_done), 32'h0);
        tick();
        chk("abort_done_later", 32'(o_done), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
